// File: rtl/mem_stage_unit_pkg.sv
// rtl/mem_stage_unit_pkg.sv - shared widths, memory-op codes and bus polarity constants
package mem_stage_unit_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int REG_ADDR_W  = 5;
    localparam int MEM_OP_W    = 2;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 2'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 2'd2;

    // Active-low strobe/enable encoding
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // SPM direction encoding
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    function automatic logic is_word_aligned(input logic [WORD_DATA_W-1:0] byte_addr);
        return (byte_addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_unit_if.sv
// rtl/mem_stage_unit_if.sv - scratch-pad memory bus interface
// Ports: spm_addr/spm_as_/spm_rw/spm_wr_data driven by master, spm_rd_data driven by slave.
interface mem_stage_unit_if;
    import mem_stage_unit_pkg::*;

    logic [WORD_ADDR_W-1:0] spm_addr;
    logic                   spm_as_;
    logic                   spm_rw;
    logic [WORD_DATA_W-1:0] spm_wr_data;
    logic [WORD_DATA_W-1:0] spm_rd_data;

    modport master (
        output spm_addr, spm_as_, spm_rw, spm_wr_data,
        input  spm_rd_data
    );

    modport slave (
        input  spm_addr, spm_as_, spm_rw, spm_wr_data,
        output spm_rd_data
    );

endinterface

// File: rtl/mem_stage_unit_mem_access_ctrl.sv
// rtl/mem_stage_unit_mem_access_ctrl.sv - memory-op decode, alignment check and result select
// Inputs : ex_en, mem_op, ex_out (byte address / EX result), ex_mem_wr_data, rd_data (gated load data)
// Outputs: addr, as_, rw, wr_data, out (stage result), miss_align
module mem_access_ctrl
    import mem_stage_unit_pkg::*;
(
    input  logic                   ex_en,
    input  logic [MEM_OP_W-1:0]    mem_op,
    input  logic [WORD_DATA_W-1:0] ex_out,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [WORD_DATA_W-1:0] rd_data,
    output logic [WORD_ADDR_W-1:0] addr,
    output logic                   as_,
    output logic                   rw,
    output logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] out,
    output logic                   miss_align
);

    logic aligned;

    assign aligned = is_word_aligned(ex_out);
    assign addr    = ex_out[WORD_DATA_W-1:2];
    assign wr_data = ex_mem_wr_data;

    always_comb begin
        as_        = DISABLE_;
        rw         = READ;
        miss_align = 1'b0;
        out        = ex_out;
        case (mem_op)
            MEM_OP_LDW: begin
                if (aligned) begin
                    as_ = ex_en ? ENABLE_ : DISABLE_;
                    out = rd_data;
                end else begin
                    miss_align = ex_en;
                    out        = '0;
                end
            end
            MEM_OP_STW: begin
                if (aligned) begin
                    as_ = ex_en ? ENABLE_ : DISABLE_;
                    // Direction only flips to WRITE while a store is actually strobed
                    rw  = ex_en ? WRITE : READ;
                end else begin
                    miss_align = ex_en;
                    out        = '0;
                end
            end
            default: ; // NOP and reserved op pass the EX result through
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM pipeline stage: SPM access control, bus mux and MEM/WB register
// Ports: clk, reset (sync active-high), stall, flush, EX/MEM inputs (ex_*),
//        spm (SPM bus, master modport), miss_align, MEM/WB outputs (mem_*).
module mem_stage_unit
    import mem_stage_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   ex_en,
    input  logic [MEM_OP_W-1:0]    ex_mem_op,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [WORD_DATA_W-1:0] ex_out,
    input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    mem_stage_unit_if.master       spm,
    output logic                   miss_align,
    output logic [WORD_DATA_W-1:0] mem_out,
    output logic [REG_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic                   mem_en
);

    logic [WORD_ADDR_W-1:0] addr;
    logic                   as_;
    logic                   rw;
    logic [WORD_DATA_W-1:0] wr_data;
    logic [WORD_DATA_W-1:0] rd_data;
    logic [WORD_DATA_W-1:0] out;
    logic                   commit;

    mem_access_ctrl u_mem_access_ctrl (
        .ex_en          (ex_en),
        .mem_op         (ex_mem_op),
        .ex_out         (ex_out),
        .ex_mem_wr_data (ex_mem_wr_data),
        .rd_data        (rd_data),
        .addr           (addr),
        .as_            (as_),
        .rw             (rw),
        .wr_data        (wr_data),
        .out            (out),
        .miss_align     (miss_align)
    );

    // Zero-wait SPM: bus follows the inputs combinationally, even under stall or reset
    assign spm.spm_addr    = addr;
    assign spm.spm_as_     = as_;
    assign spm.spm_rw      = rw;
    assign spm.spm_wr_data = wr_data;
    assign rd_data         = (as_ == ENABLE_) ? spm.spm_rd_data : '0;

    assign commit = ex_en & ~miss_align;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mem_out      <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= DISABLE_;
            mem_en       <= 1'b0;
        end else if (!stall) begin
            mem_out      <= out;
            mem_dst_addr <= ex_dst_addr;
            mem_en       <= commit;
            mem_gpr_we_  <= commit ? ex_gpr_we_ : DISABLE_;
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        reset, stall, flush, ex_en, ex_gpr_we_;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        miss_align;
    logic [31:0] mem_out;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_, mem_en;

    int checks = 0;
    int errors = 0;

    mem_stage_unit_if spm ();

    mem_stage_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_en          (ex_en),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_out         (ex_out),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .spm            (spm.master),
        .miss_align     (miss_align),
        .mem_out        (mem_out),
        .mem_dst_addr   (mem_dst_addr),
        .mem_gpr_we_    (mem_gpr_we_),
        .mem_en         (mem_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] ex_out;
        logic [31:0] wr_data;
        logic [31:0] rd_data;
        logic        en;
        logic        we_;
        logic [4:0]  dst;
        logic [29:0] e_addr;
        logic        e_as;
        logic        e_rw;
        logic        e_miss;
        logic [31:0] e_out;
        logic        e_we_;
        logic        e_en;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic [4:0]  dst;
        logic        we_;
        logic        en;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] eo, input logic [31:0] wd,
                         input logic [31:0] rd, input logic en, input logic we, input logic [4:0] dst);
        ex_mem_op       = op;
        ex_out          = eo;
        ex_mem_wr_data  = wd;
        spm.spm_rd_data = rd;
        ex_en           = en;
        ex_gpr_we_      = we;
        ex_dst_addr     = dst;
    endtask

    task automatic check_mem(input string tag, input logic [31:0] o, input logic [4:0] d,
                             input logic w, input logic e);
        chk({tag, ".mem_out"}, mem_out, o);
        chk({tag, ".mem_dst_addr"}, 32'(mem_dst_addr), 32'(d));
        chk({tag, ".mem_gpr_we_"}, 32'(mem_gpr_we_), 32'(w));
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(e));
    endtask

    initial begin
        exp_t e;
        //           op     ex_out        wr_data       rd_data       en  we dst  addr          as rw ms out           we en
        vecs[0] = '{2'd1, 32'h154,      32'h999,      32'h24,       1, 0, 3,  30'h55,       0, 1, 0, 32'h24,       0, 1};
        vecs[1] = '{2'd2, 32'h100,      32'hDEADBEEF, 32'h5,        1, 1, 7,  30'h40,       0, 0, 0, 32'h100,      1, 1};
        vecs[2] = '{2'd1, 32'h155,      32'h0,        32'hAAAA,     1, 0, 4,  30'h55,       1, 1, 1, 32'h0,        1, 0};
        vecs[3] = '{2'd0, 32'h1234,     32'h11,       32'hFFFF,     1, 0, 9,  30'h48D,      1, 1, 0, 32'h1234,     0, 1};
        vecs[4] = '{2'd2, 32'h102,      32'hCAFE,     32'h0,        1, 1, 2,  30'h40,       1, 1, 1, 32'h0,        1, 0};
        vecs[5] = '{2'd3, 32'h77,       32'h3,        32'h88,       1, 0, 31, 30'h1D,       1, 1, 0, 32'h77,       0, 1};
        vecs[6] = '{2'd1, 32'h200,      32'h0,        32'h4321,     0, 0, 6,  30'h80,       1, 1, 0, 32'h0,        1, 0};
        vecs[7] = '{2'd1, 32'hFFFFFFFC, 32'h1,        32'h13579BDF, 1, 0, 1,  30'h3FFFFFFF, 0, 1, 0, 32'h13579BDF, 0, 1};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_mem("reset", 32'h0, 5'd0, 1'b1, 1'b0);

        // Table-driven vectors with a scoreboard for the registered outputs
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].ex_out, vecs[i].wr_data, vecs[i].rd_data,
                  vecs[i].en, vecs[i].we_, vecs[i].dst);
            #1;
            chk($sformatf("v%0d.spm_addr", i), 32'(spm.spm_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d.spm_as_", i), 32'(spm.spm_as_), 32'(vecs[i].e_as));
            chk($sformatf("v%0d.spm_rw", i), 32'(spm.spm_rw), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d.spm_wr_data", i), spm.spm_wr_data, vecs[i].wr_data);
            chk($sformatf("v%0d.miss_align", i), 32'(miss_align), 32'(vecs[i].e_miss));
            sb.push_back('{vecs[i].e_out, vecs[i].dst, vecs[i].e_we_, vecs[i].e_en});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d.scoreboard: queue empty", i);
            end else begin
                e = sb.pop_front();
                check_mem($sformatf("v%0d", i), e.out, e.dst, e.we_, e.en);
            end
        end

        // Stall holds state A while the SPM strobe still follows the new inputs
        @(negedge clk);
        drive(2'd1, 32'h300, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 5'd12);
        @(posedge clk); #1;
        check_mem("stateA", 32'hA5A5A5A5, 5'd12, 1'b0, 1'b1);
        @(negedge clk);
        stall = 1'b1;
        drive(2'd2, 32'h404, 32'h77777777, 32'h0, 1'b1, 1'b1, 5'd20);
        #1;
        chk("stall.spm_as_", 32'(spm.spm_as_), 32'h0);
        chk("stall.spm_rw", 32'(spm.spm_rw), 32'h0);
        @(posedge clk); #1;
        check_mem("stall", 32'hA5A5A5A5, 5'd12, 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b1; // flush outranks stall
        @(posedge clk); #1;
        check_mem("flush", 32'h0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;

        // Reset mid-access: registered outputs clear, bus keeps following inputs
        drive(2'd1, 32'h10, 32'h0, 32'h5555, 1'b1, 1'b0, 5'd8);
        @(posedge clk); #1;
        check_mem("pre_reset", 32'h5555, 5'd8, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset.spm_as_", 32'(spm.spm_as_), 32'h0);
        @(posedge clk); #1;
        check_mem("mid_reset", 32'h0, 5'd0, 1'b1, 1'b0);
        chk("reset.spm_as_post", 32'(spm.spm_as_), 32'h0);
        chk("reset.spm_addr", 32'(spm.spm_addr), 32'h4);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- MEM pipeline stage of the CPU.
- Decodes the EX/MEM memory operation, checks word alignment and drives the scratch-pad memory (SPM) bus.
- Selects either the load data or the EX result, and registers that result into the MEM/WB pipeline register.
- Combines two functions, memory access control and the SPM bus interface, plus the MEM/WB register.

Parameters:
- WORD_DATA_W, 32, data word width.
- WORD_ADDR_W, 30, word address width (byte address bits [31:2]).
- REG_ADDR_W, 5, GPR address width.
- MEM_OP_W, 2, memory-op code width.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  invalidate the MEM/WB register.
- ex_en  in  1  EX/MEM entry valid.
- ex_mem_op  in  2  memory op: NOP=0, LDW=1, STW=2, 3 reserved (treated as NOP).
- ex_mem_wr_data  in  32  store data.
- ex_out  in  32  EX result / byte address.
- ex_dst_addr  in  5  GPR write address.
- ex_gpr_we_  in  1  GPR write enable, active-low.
- spm_rd_data  in  32  SPM read data, combinational.
- spm_addr  out  30  SPM word address.
- spm_as_  out  1  SPM address strobe, active-low.
- spm_rw  out  1  SPM direction: READ=1, WRITE=0.
- spm_wr_data  out  32  SPM write data.
- miss_align  out  1  combinational misalignment flag.
- mem_out  out  32  MEM/WB result.
- mem_dst_addr  out  5  MEM/WB GPR address.
- mem_gpr_we_  out  1  MEM/WB write enable, active-low.
- mem_en  out  1  MEM/WB valid.

Behaviour:
- Active-low encoding: ENABLE_=0, DISABLE_=1. READ=1, WRITE=0.
- Access control (combinational):
  - addr = ex_out[31:2].
  - wr_data = ex_mem_wr_data, always forwarded regardless of op.
  - LDW with ex_out[1:0]==0: as_=ENABLE_, rw=READ, out=rd_data.
  - STW with ex_out[1:0]==0: as_=ENABLE_, rw=WRITE, out=ex_out.
  - LDW/STW with ex_out[1:0]!=0: miss_align=1, as_=DISABLE_, rw=READ, out=0.
  - NOP or reserved op: as_=DISABLE_, rw=READ, out=ex_out, miss_align=0.
  - ex_en=0: as_=DISABLE_ and miss_align=0 regardless of op.
- Bus interface (combinational):
  - spm_addr = addr; spm_rw = rw; spm_wr_data = wr_data.
  - spm_as_ = as_.
  - rd_data = spm_rd_data when as_==ENABLE_, else 0.
- Zero-wait SPM: load data is valid in the same cycle the address is presented. No handshake, no multi-cycle access.
- MEM/WB register (rising clk), priority reset > flush > stall > load:
  - reset: mem_out=0, mem_dst_addr=0, mem_gpr_we_=DISABLE_, mem_en=0.
  - flush: same values as reset.
  - stall: all outputs hold.
  - otherwise: mem_out<=out, mem_dst_addr<=ex_dst_addr, mem_en<=ex_en & ~miss_align, mem_gpr_we_<=ex_gpr_we_ when ex_en & ~miss_align, else DISABLE_.
- Stall asserted: the SPM strobe still follows the inputs. The upstream stage must hold the EX/MEM inputs so that a store is not duplicated with different data.
- Reset mid-access: the combinational SPM outputs still follow the inputs. Only the registered outputs clear.
- Latency: spm_* outputs and miss_align are 0 cycles from the inputs. mem_* outputs are 1 cycle.

Decomposition:
- Shared package holds:
  - widths: WORD_DATA_W, WORD_ADDR_W, REG_ADDR_W, MEM_OP_W;
  - MEM_OP_NOP/LDW/STW codes;
  - ENABLE_/DISABLE_ and READ/WRITE constants.
- Sub-module mem_access_ctrl: op decode, alignment check and result select.
- The SPM bus mux and the MEM/WB register stay in the top level.

Test Plan:
- Aligned load: op=LDW, ex_out=0x154, ex_mem_wr_data=0x999, spm_rd_data=0x24, ex_en=1, ex_gpr_we_=0, ex_dst_addr=3.
  - Same cycle: spm_addr=0x55, spm_as_=0, spm_rw=1, spm_wr_data=0x999, miss_align=0.
  - Next edge: mem_out=0x24, mem_dst_addr=3, mem_gpr_we_=0, mem_en=1.
- Aligned store: op=STW, ex_out=0x100, wr_data=0xDEADBEEF.
  - spm_addr=0x40, spm_as_=0, spm_rw=0, spm_wr_data=0xDEADBEEF.
  - Next edge: mem_out=0x100.
- Misaligned load: op=LDW, ex_out=0x155.
  - miss_align=1, spm_as_=1.
  - Next edge: mem_gpr_we_=1, mem_en=0, mem_out=0.
- NOP passthrough: op=NOP, ex_out=0x1234, spm_rd_data=0xFFFF.
  - spm_as_=1.
  - Next edge: mem_out=0x1234.
- Stall then flush: load state A, assert stall with new inputs → mem_* hold A. Assert flush → mem_out=0, mem_gpr_we_=1, mem_en=0.
- Reset: assert reset for one edge with LDW active.
  - mem_* take reset values.
  - spm_as_ stays 0 (combinational).
